// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// State encodings are fixed so they line up with existing debug tooling.
package mem_arbiter_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 16;

  localparam logic [1:0] FUNC_READ  = 2'd0;
  localparam logic [1:0] FUNC_WRITE = 2'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. Returns the one-hot winner and its index.
module mem_arbiter_rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int N = N_REQ_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        win_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared memory_unit port.
// Define MEM_ARB_LOCK_EN to add req_lock for atomic multi-access sequences.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [2*N_REQ-1:0]  req_func,
  input  logic [ADDR_W*N_REQ-1:0] req_addr1,
  input  logic [ADDR_W*N_REQ-1:0] req_addr2,
  input  logic [DATA_W*N_REQ-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]    req_lock,
`endif
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic [1:0]          mem_func,
  output logic                mem_execute,
  output logic [ADDR_W-1:0]   address1,
  output logic [ADDR_W-1:0]   address2,
  output logic [DATA_W-1:0]   write_data,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   read_data1,
  input  logic [DATA_W-1:0]   read_data2
);

  localparam int IW = idx_w(N_REQ);

  arb_state_e        state_q;
  logic [IW-1:0]     ptr_q, gidx_q;
  logic [N_REQ-1:0]  gnt_q, done_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, wdata_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic [1:0]        func_q;
  logic              exec_q;

  logic [N_REQ-1:0]  req_eff, win;
  logic [IW-1:0]     pick_ptr, win_idx;
  logic              win_any;
  logic [1:0]        sel_func;
  logic [ADDR_W-1:0] sel_addr1, sel_addr2;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

`ifdef MEM_ARB_LOCK_EN
  logic lock_q, lock_hold;
  // While locked, ptr_q holds the owner; releasing resumes round-robin after it.
  assign lock_hold = lock_q && req_lock[ptr_q];
  assign pick_ptr  = (lock_q && !lock_hold) ? next_idx(ptr_q) : ptr_q;
  assign req_eff   = lock_hold ? (req & (N_REQ'(1) << ptr_q)) : req;
`else
  assign pick_ptr  = ptr_q;
  assign req_eff   = req;
`endif

  mem_arbiter_rr_picker #(.N(N_REQ)) u_picker (
    .req_i (req_eff),
    .ptr_i (pick_ptr),
    .win_o (win),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    sel_func  = '0;
    sel_addr1 = '0;
    sel_addr2 = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_func  = req_func[2*i +: 2];
        sel_addr1 = req_addr1[ADDR_W*i +: ADDR_W];
        sel_addr2 = req_addr2[ADDR_W*i +: ADDR_W];
        sel_wdata = req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      wdata_q <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      func_q  <= '0;
      exec_q  <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      exec_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef MEM_ARB_LOCK_EN
          if (lock_q && !lock_hold) begin
            lock_q <= 1'b0;
            ptr_q  <= pick_ptr;
          end
`endif
          if (mem_ready && win_any) begin
            gnt_q   <= win;
            gidx_q  <= win_idx;
            func_q  <= sel_func;
            addr1_q <= sel_addr1;
            addr2_q <= sel_addr2;
            wdata_q <= sel_wdata;
            exec_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT_LO;
        WAIT_LO: if (!mem_ready) state_q <= WAIT_HI;
        WAIT_HI: begin
          if (mem_ready) begin
            rd1_q   <= read_data1;
            rd2_q   <= read_data2;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= IDLE;
`ifdef MEM_ARB_LOCK_EN
            lock_q  <= req_lock[gidx_q];
            ptr_q   <= req_lock[gidx_q] ? gidx_q : next_idx(gidx_q);
`else
            ptr_q   <= next_idx(gidx_q);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rd_data1    = rd1_q;
  assign rd_data2    = rd2_q;
  assign mem_func    = func_q;
  assign mem_execute = exec_q;
  assign address1    = addr1_q;
  assign address2    = addr2_q;
  assign write_data  = wdata_q;

endmodule
